// File: rtl/dsp_pkg.sv
// Shared definitions for display cell-port initiators: address field widths,
// default screen geometry and the initiator state encoding.
package dsp_pkg;

    localparam int DSP_ROW_W    = 5;
    localparam int DSP_COL_W    = 7;
    localparam int DSP_ADDR_W   = DSP_ROW_W + DSP_COL_W;
    localparam int DSP_DATA_W   = 16;
    localparam int DSP_ROWS_DEF = 30;
    localparam int DSP_COLS_DEF = 80;

    typedef enum logic [2:0] {
        DSP_IDLE = 3'd0,
        DSP_RD   = 3'd1,
        DSP_WR   = 3'd2,
        DSP_FILL = 3'd3,
        DSP_DONE = 3'd4
    } dsp_state_t;

    // Cell address as seen by the slave: row in the upper field, column below.
    function automatic logic [DSP_ADDR_W-1:0] dsp_cell_addr(
        input logic [DSP_ROW_W-1:0] row,
        input logic [DSP_COL_W-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/dsp_cell_cnt.sv
// Row/column cell counter. load sets the row and clears the column; inc walks
// columns and wraps into the next row, holding on the last row.
module dsp_cell_cnt
    import dsp_pkg::*;
#(
    parameter int ROWS = DSP_ROWS_DEF,
    parameter int COLS = DSP_COLS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DSP_ROW_W-1:0] load_row,
    input  logic                 inc,
    output logic [DSP_ROW_W-1:0] row,
    output logic [DSP_COL_W-1:0] col,
    output logic                 last_col,
    output logic                 last_row
);

    localparam logic [DSP_ROW_W-1:0] LAST_ROW = DSP_ROW_W'(ROWS - 1);
    localparam logic [DSP_COL_W-1:0] LAST_COL = DSP_COL_W'(COLS - 1);

    logic [DSP_ROW_W-1:0] row_reg, row_next;
    logic [DSP_COL_W-1:0] col_reg, col_next;

    assign row      = row_reg;
    assign col      = col_reg;
    assign last_col = (col_reg == LAST_COL);
    assign last_row = (row_reg == LAST_ROW);

    // Next counter value: load wins over increment; the row never passes the last row.
    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (load) begin
            row_next = load_row;
            col_next = '0;
        end else if (inc) begin
            if (last_col) begin
                col_next = '0;
                if (!last_row) begin
                    row_next = row_reg + 1'b1;
                end
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

endmodule

// File: rtl/dsp_scroll.sv
// Scrolls the text screen up one row through the display cell port: copies
// rows 1..ROWS-1 into the row above, then fills the bottom row with a word.
module dsp_scroll
    import dsp_pkg::*;
#(
    parameter int ROWS = DSP_ROWS_DEF,
    parameter int COLS = DSP_COLS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DSP_DATA_W-1:0] fill_data,
    output logic                  busy,
    output logic                  done,
    output logic [DSP_ADDR_W-1:0] addr,
    output logic                  en,
    output logic                  wr,
    input  logic                  wt,
    output logic [DSP_DATA_W-1:0] data_out,
    input  logic [DSP_DATA_W-1:0] data_in
);

    // A one-row screen has nothing to copy and goes straight to the fill pass.
    localparam logic [DSP_ROW_W-1:0] FIRST_ROW   = (ROWS > 1) ? DSP_ROW_W'(1) : '0;
    localparam dsp_state_t           FIRST_STATE = (ROWS > 1) ? DSP_RD : DSP_FILL;
    localparam logic [DSP_ROW_W-1:0] LAST_ROW    = DSP_ROW_W'(ROWS - 1);

    dsp_state_t            state_reg, state_next;
    logic [DSP_DATA_W-1:0] cap_reg;
    logic [DSP_DATA_W-1:0] fill_reg;

    logic                  cnt_load;
    logic [DSP_ROW_W-1:0]  cnt_load_row;
    logic                  cnt_inc;
    logic [DSP_ROW_W-1:0]  cnt_row;
    logic [DSP_COL_W-1:0]  cnt_col;
    logic                  cnt_last_col;
    logic                  cnt_last_row;
    logic [DSP_ROW_W-1:0]  prev_row;

    dsp_cell_cnt #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_row (cnt_load_row),
        .inc      (cnt_inc),
        .row      (cnt_row),
        .col      (cnt_col),
        .last_col (cnt_last_col),
        .last_row (cnt_last_row)
    );

    assign prev_row = cnt_row - 1'b1;

    // Next-state and counter control.
    always_comb begin
        state_next   = state_reg;
        cnt_load     = 1'b0;
        cnt_load_row = '0;
        cnt_inc      = 1'b0;
        unique case (state_reg)
            DSP_IDLE: begin
                if (start) begin
                    cnt_load     = 1'b1;
                    cnt_load_row = FIRST_ROW;
                    state_next   = FIRST_STATE;
                end
            end
            DSP_RD: begin
                if (!wt) begin
                    state_next = DSP_WR;
                end
            end
            DSP_WR: begin
                cnt_inc    = 1'b1;
                state_next = (cnt_last_col && cnt_last_row) ? DSP_FILL : DSP_RD;
            end
            DSP_FILL: begin
                cnt_inc = 1'b1;
                if (cnt_last_col) begin
                    state_next = DSP_DONE;
                end
            end
            DSP_DONE: begin
                state_next = DSP_IDLE;
            end
            default: begin
                state_next = DSP_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= DSP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fill word latched on an accepted start; read data captured when the slave releases wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_reg <= '0;
            cap_reg  <= '0;
        end else begin
            if (state_reg == DSP_IDLE && start) begin
                fill_reg <= fill_data;
            end
            if (state_reg == DSP_RD && !wt) begin
                cap_reg <= data_in;
            end
        end
    end

    // Bus outputs decoded from registered state and counters only.
    always_comb begin
        en       = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        data_out = '0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_reg)
            DSP_RD: begin
                en   = 1'b1;
                busy = 1'b1;
                addr = dsp_cell_addr(cnt_row, cnt_col);
            end
            DSP_WR: begin
                en       = 1'b1;
                wr       = 1'b1;
                busy     = 1'b1;
                addr     = dsp_cell_addr(prev_row, cnt_col);
                data_out = cap_reg;
            end
            DSP_FILL: begin
                en       = 1'b1;
                wr       = 1'b1;
                busy     = 1'b1;
                addr     = dsp_cell_addr(LAST_ROW, cnt_col);
                data_out = fill_reg;
            end
            DSP_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dsp_scroll.sv
// Bench for dsp_scroll: three sizes (30x80, 1x4, 2x1), each with its own cell
// memory slave and a transaction-level model of the scroll.
module tb_dsp_scroll;

    typedef struct packed {
        logic        w;
        logic [11:0] a;
        logic [15:0] d;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic        reset_v     [3];
    logic        start_v     [3];
    logic        wait_rand_v [3];
    logic [15:0] fill_v      [3];
    logic        busy_v      [3];
    logic        done_v      [3];
    logic        en_v        [3];
    logic        wr_v        [3];
    logic [11:0] addr_v      [3];
    logic [15:0] dout_v      [3];

    logic [15:0] mem [3][32][128];
    int          done_cnt [3];

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int R = (gi == 0) ? 30 : ((gi == 1) ? 1 : 2);
        localparam int C = (gi == 0) ? 80 : ((gi == 1) ? 4 : 1);

        logic        wt_s;
        logic [15:0] din_s;

        dsp_scroll #(
            .ROWS(R),
            .COLS(C)
        ) u_dut (
            .clk       (clk),
            .reset     (reset_v[gi]),
            .start     (start_v[gi]),
            .fill_data (fill_v[gi]),
            .busy      (busy_v[gi]),
            .done      (done_v[gi]),
            .addr      (addr_v[gi]),
            .en        (en_v[gi]),
            .wr        (wr_v[gi]),
            .wt        (wt_s),
            .data_out  (dout_v[gi]),
            .data_in   (din_s)
        );

        txn_t        exp_q [$];
        logic [15:0] exp_img [32][128];
        bit          rd_active;
        bit          m_busy;
        int          rd_left;
        logic [11:0] rd_addr;
        int          t_first;
        int          exp_done;
        int          last_txn;

        initial begin
            wt_s      = 1'b0;
            din_s     = 16'h0;
            rd_active = 1'b0;
            m_busy    = 1'b0;
        end

        // Slave model and scoreboard; DUT outputs are sampled mid-cycle.
        always @(negedge clk) begin : p_chk
            txn_t t;
            int   bad;
            if (reset_v[gi]) begin
                rd_active = 1'b0;
                m_busy    = 1'b0;
                exp_q.delete();
                wt_s      = 1'b0;
            end else begin
                // Accept: the scroll as a list of bus transactions plus its final image.
                if (start_v[gi] && !m_busy) begin
                    m_busy   = 1'b1;
                    t_first  = cyc + 1;
                    last_txn = cyc;
                    exp_q.delete();
                    for (int r = 0; r < R; r++)
                        for (int c = 0; c < C; c++)
                            exp_img[r][c] = (r < R - 1) ? mem[gi][r+1][c] : fill_v[gi];
                    for (int r = 1; r < R; r++)
                        for (int c = 0; c < C; c++) begin
                            exp_q.push_back('{1'b0, {5'(r), 7'(c)}, mem[gi][r][c]});
                            exp_q.push_back('{1'b1, {5'(r - 1), 7'(c)}, mem[gi][r][c]});
                        end
                    for (int c = 0; c < C; c++)
                        exp_q.push_back('{1'b1, {5'(R - 1), 7'(c)}, fill_v[gi]});
                    exp_done = t_first + ((R > 1) ? (R - 1) * C * 3 : 0) + C;
                end

                if (m_busy && cyc >= t_first)
                    check_eq($sformatf("i%0d busy", gi), busy_v[gi], !done_v[gi]);
                else
                    check_eq($sformatf("i%0d idle_busy_done", gi), {busy_v[gi], done_v[gi]}, 0);

                if (!(en_v[gi] && wr_v[gi]))
                    check_eq($sformatf("i%0d dout_zero", gi), dout_v[gi], 0);

                // Read: hold checks while waiting, completion when wt is low.
                if (rd_active)
                    check_eq($sformatf("i%0d rd_hold", gi),
                             {en_v[gi], wr_v[gi], addr_v[gi]}, {1'b1, 1'b0, rd_addr});
                else if (en_v[gi] && !wr_v[gi]) begin
                    rd_active = 1'b1;
                    rd_addr   = addr_v[gi];
                    rd_left   = wait_rand_v[gi] ? int'($urandom_range(0, 5)) : 1;
                end
                if (rd_active) begin
                    wt_s  = (rd_left != 0);
                    din_s = mem[gi][rd_addr[11:7]][rd_addr[6:0]];
                    if (rd_left == 0) begin
                        rd_active = 1'b0;
                        check_eq($sformatf("i%0d txn_avail", gi), exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            t = exp_q.pop_front();
                            check_eq($sformatf("i%0d txn_kind", gi), 0, t.w);
                            check_eq($sformatf("i%0d rd_addr", gi), rd_addr, t.a);
                        end
                        last_txn = cyc;
                    end else begin
                        rd_left--;
                    end
                end else begin
                    wt_s  = 1'($urandom_range(0, 1));
                    din_s = 16'($urandom);
                end

                // Write: must directly follow the previous transaction.
                if (en_v[gi] && wr_v[gi]) begin
                    check_eq($sformatf("i%0d txn_avail", gi), exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        check_eq($sformatf("i%0d txn_kind", gi), 1, t.w);
                        check_eq($sformatf("i%0d wr_addr", gi), addr_v[gi], t.a);
                        check_eq($sformatf("i%0d wr_data", gi), dout_v[gi], t.d);
                    end
                    check_eq($sformatf("i%0d wr_adjacent", gi), cyc, last_txn + 1);
                    last_txn = cyc;
                    mem[gi][addr_v[gi][11:7]][addr_v[gi][6:0]] = dout_v[gi];
                end

                if (done_v[gi]) begin
                    done_cnt[gi]++;
                    check_eq($sformatf("i%0d done_expected", gi), m_busy, 1);
                    check_eq($sformatf("i%0d txn_left", gi), exp_q.size(), 0);
                    if (!wait_rand_v[gi])
                        check_eq($sformatf("i%0d done_cyc", gi), cyc, exp_done);
                    bad = 0;
                    for (int r = 0; r < R; r++)
                        for (int c = 0; c < C; c++)
                            if (mem[gi][r][c] !== exp_img[r][c]) bad++;
                    check_eq($sformatf("i%0d image_bad", gi), bad, 0);
                    m_busy = 1'b0;
                end
            end
        end
    end

    // One scroll with optional extra start pulses at cycles x1/x2 of the run.
    task automatic run_scroll(input int i, input logic [15:0] fill, input int budget,
                              input int x1, input int x2);
        int d0;
        d0 = done_cnt[i];
        fill_v[i]  = fill;
        start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        fill_v[i]  = 16'($urandom);
        for (int n = 1; n <= budget; n++) begin
            start_v[i] = (n == x1 || n == x2);
            @(posedge clk); #1;
            if (done_cnt[i] != d0) break;
        end
        start_v[i] = 1'b0;
        check_eq($sformatf("i%0d done_seen", i), done_cnt[i] - d0, 1);
        $display("scroll inst=%0d fill=%04h done_count=%0d cycle=%0d", i, fill, done_cnt[i], cyc);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 3; i++) begin
            reset_v[i]     = 1'b1;
            start_v[i]     = 1'b0;
            wait_rand_v[i] = 1'b0;
            fill_v[i]      = 16'h0;
            done_cnt[i]    = 0;
        end
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 128; c++) begin
                mem[0][r][c] = 16'((r << 7) | c);
                mem[1][r][c] = 16'($urandom);
                mem[2][r][c] = 16'h0;
            end
        mem[2][0][0] = 16'hAAAA;
        mem[2][1][0] = 16'h5555;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_en",   en_v[0],   0);
        check_eq("rst_wr",   wr_v[0],   0);
        check_eq("rst_addr", addr_v[0], 0);
        check_eq("rst_dout", dout_v[0], 0);
        check_eq("rst_busy", busy_v[0], 0);
        check_eq("rst_done", done_v[0], 0);
        for (int i = 0; i < 3; i++) reset_v[i] = 1'b0;
        @(posedge clk); #1;

        // Full scroll with real display timing; stray starts ignored.
        d0 = done_cnt[0];
        run_scroll(0, 16'h0720, 8000, 10, 5000);
        repeat (20) @(posedge clk);
        #1;
        check_eq("done_once", done_cnt[0] - d0, 1);
        check_eq("pin_0_0",   mem[0][0][0],   16'h0080);
        check_eq("pin_0_79",  mem[0][0][79],  16'h00CF);
        check_eq("pin_28_79", mem[0][28][79], 16'h0ECF);
        check_eq("pin_29_0",  mem[0][29][0],  16'h0720);
        check_eq("pin_29_79", mem[0][29][79], 16'h0720);

        // Asynchronous reset in the middle of the copy phase.
        fill_v[0]  = 16'h5A5A;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3000) @(posedge clk);
        #2;
        reset_v[0] = 1'b1;
        #1;
        check_eq("arst_en",   en_v[0],   0);
        check_eq("arst_wr",   wr_v[0],   0);
        check_eq("arst_busy", busy_v[0], 0);
        check_eq("arst_done", done_v[0], 0);
        check_eq("arst_addr", addr_v[0], 0);
        check_eq("arst_dout", dout_v[0], 0);
        $display("reset inst=0 asserted at cycle=%0d", cyc);
        @(posedge clk); #1;
        reset_v[0] = 1'b0;
        @(posedge clk); #1;
        run_scroll(0, 16'h0041, 8000, 0, 0);

        // Slave with 0..5 random wait cycles per read.
        wait_rand_v[0] = 1'b1;
        run_scroll(0, 16'hBEEF, 20000, 0, 0);
        wait_rand_v[0] = 1'b0;

        // One-row screen: fill only.
        run_scroll(1, 16'h1234, 100, 0, 0);
        for (int c = 0; c < 4; c++)
            check_eq($sformatf("pin_r1_c%0d", c), mem[1][0][c], 16'h1234);

        // Two rows, one column: one copy then one fill.
        run_scroll(2, 16'h0F0F, 100, 0, 0);
        check_eq("pin_2x1_r0", mem[2][0][0], 16'h5555);
        check_eq("pin_2x1_r1", mem[2][1][0], 16'h0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_scroll.md
# dsp_scroll

Bus initiator for the text display's cell-memory port: on a start pulse it scrolls the character screen up by one row. It reads every cell of rows 1..ROWS-1 through the display's en/wr/wt port, rewrites each into the row above, then fills the bottom row with a caller-supplied cell word. It sits between the CPU-side control register logic and the display slave, and owns the slave port while busy.

## Interface
- ROWS, 30, text rows on screen (1..32)
- COLS, 80, text columns on screen (1..128)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- fill_data  in  16  cell word (attribute+char) written to the bottom row; latched on accepted start
- busy  out  1  high while the scroll is in progress
- done  out  1  one-cycle pulse when the scroll completes
- addr  out  12 [13:2]  cell address to slave: addr[13:9]=row, addr[8:2]=column
- en  out  1  slave access enable
- wr  out  1  1=write, 0=read
- wt  in  1  slave wait; meaningful for reads only
- data_out  out  16  write data to slave
- data_in  in  16  read data from slave

## Operation
- FSM states: IDLE, RD, WR, FILL, DONE. Counters row (5 b), col (7 b), capture register cap (16 b), fill register (16 b).
- IDLE: en=0, busy=0. start=1 -> latch fill_data, col=0; row=1 and go RD if ROWS>1, else row=0 and go FILL.
- RD: en=1, wr=0, addr={row,col}. Stay while wt=1. At an edge with wt=0: cap<=data_in, go WR.
- WR: en=1, wr=1, addr={row-1,col}, data_out=cap. One cycle, wt ignored. Then advance: col=COLS-1 -> col=0, row+1; if that row equals ROWS, row=ROWS-1 and go FILL, else RD. Otherwise col+1, RD.
- FILL: en=1, wr=1, addr={ROWS-1,col}, data_out=fill. One cycle per cell; col=COLS-1 -> DONE, else col+1.
- DONE: en=0, busy=0, done=1 for one cycle; -> IDLE.
- Outputs decode from registered state/counters only; no combinational path from wt or start to any output.
- Unused address bits (row>=ROWS, col>=COLS) never driven; data_out=0 whenever wr=0 or en=0.
- start during non-IDLE states ignored (no queueing).

## Timing
- Reset (async assert): state=IDLE; en=0, wr=0, addr=0, data_out=0, busy=0, done=0; counters/cap/fill cleared. Mid-scroll reset aborts immediately; screen left partially scrolled, no recovery.
- start sampled at edge N -> en/busy high from cycle N+1.
- Read latency: data captured at the first edge where en=1, wr=0, wt=0. Display slave gives wt=1 for exactly one cycle -> 2 cycles/read, so 3 cycles per copied cell.
- With that slave and defaults: busy high 29*80*3 + 80 = 7040 cycles; done in cycle N+7041; new start accepted from the following edge.
- Each WR follows its RD's capture with no gap; consecutive writes in FILL are back-to-back.
- Arbitrary extra wait cycles in RD stretch only that read; addr/en/wr held stable throughout.

## Structure
- Shared package dsp_pkg: DSP_ROW_W=5, DSP_COL_W=7, default ROWS/COLS, state encoding constants (shared with other display-port initiators).
- One natural sub-module: dsp_cell_cnt (row/column counter with load, increment, column wrap and last-row/last-cell flags). FSM and datapath stay in dsp_scroll.

## Test plan
- Default size, slave model = real display timing (wt 1 cycle), distinct pattern per cell (word = {row,col}), fill_data=16'h0720 -> after done, cell(r,c)={r+1,c} for r<29, row 29 all 16'h0720; done at start+7041.
- Slave with 0..5 random wait cycles per read -> same final memory image; addr/en/wr stable while wt=1; no write issued before the matching read completes.
- start pulsed again at cycles 10 and 5000 of a scroll -> ignored; exactly one done pulse; second start after done runs a second full scroll.
- reset asserted mid-copy (cycle 3000), asynchronous to clk -> en, wr, busy, done 0 before next edge; addr=0; subsequent start runs a clean scroll.
- ROWS=1, COLS=4 -> no reads; exactly 4 writes to row 0 cols 0..3 with fill_data, done at start+5.
- ROWS=2, COLS=1 -> read (1,0), write (0,0), fill write (1,0); checks row/col wrap and last-row transition.
